// File: rtl/arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int unsigned DefaultLineWidth = 256;
  localparam int unsigned DefaultAddrWidth = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-base priority picker: the first pending port at or after
// `base` (wrapping) wins. A base of zero gives plain lowest-index priority.
module rr_pick #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         pending,
  input  logic [$clog2(NUM_PORTS)-1:0] base,
  output logic [$clog2(NUM_PORTS)-1:0] idx,
  output logic                         valid
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  logic [IdxW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IdxW'((32'(base) + k) % NUM_PORTS);
      if (!valid && pending[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port cache-line arbiter onto a single downstream port with a frozen request snapshot.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned LINE_WIDTH = DefaultLineWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [LINE_WIDTH-1:0]                req_rdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [$clog2(NUM_PORTS)-1:0]         grant_id,
  output logic                                 grant_valid,
  output logic [ADDR_WIDTH-1:0]                arb_mem_address,
  output logic                                 arb_mem_read,
  output logic                                 arb_mem_write,
  output logic [LINE_WIDTH-1:0]                arb_mem_wdata,
  input  logic [LINE_WIDTH-1:0]                arb_mem_rdata,
  input  logic                                 arbiter_resp
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  arb_state_t              state_q, state_d;
  arb_op_t                 op_q, op_d;
  logic [IdxW-1:0]         gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

  logic [IdxW-1:0]         base;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0]         last_q, last_d;
  assign base = (last_q == IdxW'(NUM_PORTS - 1)) ? '0 : last_q + IdxW'(1);
`else
  assign base = '0;
`endif

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .pending (req_read | req_write),
    .base    (base),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign req_rdata = arb_mem_rdata;

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    gnt_d           = gnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d          = last_q;
    grant_id        = gnt_q;
`else
    grant_id        = '0;
`endif
    req_resp        = '0;
    grant_valid     = 1'b0;
    arb_mem_read    = 1'b0;
    arb_mem_write   = 1'b0;
    arb_mem_address = '0;
    arb_mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // Write wins if a port illegally raises both strobes.
          op_d    = req_write[pick_idx] ? OP_WRITE : OP_READ;
          gnt_d   = pick_idx;
          addr_d  = req_addr[pick_idx];
          wdata_d = req_wdata[pick_idx];
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick_idx;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant_valid     = 1'b1;
        grant_id        = gnt_q;
        arb_mem_read    = (op_q == OP_READ);
        arb_mem_write   = (op_q == OP_WRITE);
        arb_mem_address = addr_q;
        arb_mem_wdata   = wdata_q;
        if (arbiter_resp) begin
          // A reset in the same cycle abandons the transaction without a completion.
          req_resp[gnt_q] = !rst;
          state_d         = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= IdxW'(NUM_PORTS - 1);
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (rst)
    (req_read & req_write) == '0);

endmodule
